mdu_unit: RTL and testbench

Multiply/divide unit for the five-stage pipeline, instantiated beside the Execute-stage ALU. It takes operands from the E-stage forwarding muxes, runs multiplies and divides over multiple cycles, and holds the architectural HI/LO registers. It drives `busy` to the hazard controller, which stalls any D-stage HI/LO-class instruction while an operation is in flight.

---
 rtl/mdu_unit.sv | 121 ++++++++++++
 tb/tb_mdu_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide beside the E-stage ALU, owning HI/LO; MADD/MADDU exist only with `MDU_MADD_EN.
// Latency: busy MULT_CYCLES / DIV_CYCLES cycles, HI/LO commit on the final edge; MTHI/MTLO write at the sampling edge.
// Backpressure: none; a start seen while cnt > 1 is dropped, and the hazard controller stalls D on busy.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    logic [CW-1:0] cnt;
    logic [31:0]   p_hi, p_lo;

    logic          accept;
    logic          last;
    logic [63:0]   cur_hilo;
    logic [63:0]   prod_s, prod_u;
    logic          div0;
    logic [31:0]   b_div, a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;

    assign busy   = (cnt != '0);
    assign last   = (cnt == CW'(1));
    assign accept = start && (cnt <= CW'(1));

    // On the completion edge the pending result is what HI/LO become, so
    // accumulate and divide-by-zero hold must start from it, not the old HI/LO.
    assign cur_hilo = last ? {p_hi, p_lo} : {hi, lo};

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign div0  = (b == 32'd0);
    assign b_div = div0 ? 32'd1 : b;
    assign a_mag = a[31] ? (32'd0 - a) : a;
    assign b_mag = b_div[31] ? (32'd0 - b_div) : b_div;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign q_s   = (a[31] ^ b_div[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s   = a[31] ? (32'd0 - r_mag) : r_mag;
    assign q_u   = a / b_div;
    assign r_u   = a % b_div;

`ifdef MDU_MADD_EN
    logic [63:0] macc_s, macc_u;
    assign macc_s = cur_hilo + prod_s;
    assign macc_u = cur_hilo + prod_u;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            p_hi <= 32'd0;
            p_lo <= 32'd0;
            hi   <= 32'd0;
            lo   <= 32'd0;
        end else begin
            if (busy) begin
                cnt <= cnt - CW'(1);
            end
            if (last) begin
                hi <= p_hi;
                lo <= p_lo;
            end
            // A start accepted on the completion edge overrides the commit above.
            if (accept) begin
                case (op)
                    OP_MULT: begin
                        {p_hi, p_lo} <= prod_s;
                        cnt          <= CW'(MULT_CYCLES);
                    end
                    OP_MULTU: begin
                        {p_hi, p_lo} <= prod_u;
                        cnt          <= CW'(MULT_CYCLES);
                    end
                    OP_DIV: begin
                        {p_hi, p_lo} <= div0 ? cur_hilo : {r_s, q_s};
                        cnt          <= CW'(DIV_CYCLES);
                    end
                    OP_DIVU: begin
                        {p_hi, p_lo} <= div0 ? cur_hilo : {r_u, q_u};
                        cnt          <= CW'(DIV_CYCLES);
                    end
                    OP_MTHI: hi <= a;
                    OP_MTLO: lo <= a;
`ifdef MDU_MADD_EN
                    OP_MADD: begin
                        {p_hi, p_lo} <= macc_s;
                        cnt          <= CW'(MULT_CYCLES);
                    end
                    OP_MADDU: begin
                        {p_hi, p_lo} <= macc_u;
                        cnt          <= CW'(MULT_CYCLES);
                    end
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed plan cases plus random ops, checked every cycle against a cycle-count/arith model.
// The model commits a pending 64-bit result when its remaining-cycle count hits zero.
module tb_mdu_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    int          m_rem = 0;
    logic [63:0] m_pend = 64'd0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("busy", 64'(busy), 64'(m_rem != 0));
            chk("hi", 64'(hi), 64'(m_hi));
            chk("lo", 64'(lo), 64'(m_lo));
        end
    end

    // Reference behaviour for one sampling edge, from arithmetic on 64-bit values.
    task automatic model_edge(input logic s, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        bit          can_take;
        longint      q, r;
        logic [63:0] t;
        can_take = (m_rem <= 1);
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) {m_hi, m_lo} = m_pend;
        end
        if (s && can_take) begin
            case (o)
                4'd1: begin m_pend = longint'($signed(x)) * longint'($signed(y)); m_rem = 5; end
                4'd2: begin m_pend = {32'd0, x} * {32'd0, y}; m_rem = 5; end
                4'd3: begin
                    if (y == 0) m_pend = {m_hi, m_lo};
                    else begin
                        q = longint'($signed(x)) / longint'($signed(y));
                        r = longint'($signed(x)) % longint'($signed(y));
                        t = {r[31:0], q[31:0]};
                        m_pend = t;
                    end
                    m_rem = 10;
                end
                4'd4: begin
                    if (y == 0) m_pend = {m_hi, m_lo};
                    else m_pend = {x % y, x / y};
                    m_rem = 10;
                end
                4'd5: m_hi = x;
                4'd6: m_lo = x;
`ifdef MDU_MADD_EN
                4'd7: begin m_pend = {m_hi, m_lo} + 64'(longint'($signed(x)) * longint'($signed(y))); m_rem = 5; end
                4'd8: begin m_pend = {m_hi, m_lo} + {32'd0, x} * {32'd0, y}; m_rem = 5; end
`endif
                default: ;
            endcase
        end
    endtask

    // Starts and ends just after a falling edge; drives, crosses one rising edge.
    task automatic step(input logic s, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        #1;
        start = s; op = o; a = x; b = y;
        @(posedge clk);
        model_edge(s, o, x, y);
        @(negedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'hFFFFFFFF;
            2: v = 32'h80000000;
            3: v = 32'd1;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int nb;
        #1 reset = 1'b1;
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;

        // MULT -2 * 3, busy counted over the run
        step(1'b1, 4'd1, 32'hFFFFFFFE, 32'd3);
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            nb++;
            idle(1);
        end
        chk("mult_busy_len", 64'(nb), 64'd5);
        chk("mult_hi", 64'(hi), 64'hFFFFFFFF);
        chk("mult_lo", 64'(lo), 64'hFFFFFFFA);

        // DIVU then MULTU on the completion edge
        step(1'b1, 4'd4, 32'd100, 32'd7);
        idle(9);
        step(1'b1, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("divu_lo", 64'(lo), 64'd14);
        chk("divu_hi", 64'(hi), 64'd2);
        chk("b2b_busy", 64'(busy), 64'd1);
        idle(5);
        chk("multu_hi", 64'(hi), 64'hFFFFFFFE);
        chk("multu_lo", 64'(lo), 64'h00000001);

        // DIV corners
        step(1'b1, 4'd3, 32'h80000000, 32'hFFFFFFFF);
        idle(10);
        chk("divovf_lo", 64'(lo), 64'h80000000);
        chk("divovf_hi", 64'(hi), 64'd0);
        step(1'b1, 4'd3, 32'hFFFFFFF9, 32'd2);
        idle(10);
        chk("divneg_lo", 64'(lo), 64'hFFFFFFFD);
        chk("divneg_hi", 64'(hi), 64'hFFFFFFFF);
        step(1'b1, 4'd5, 32'h11, 32'd0);
        step(1'b1, 4'd6, 32'h22, 32'd0);
        step(1'b1, 4'd3, 32'd5, 32'd0);
        chk("div0_busy", 64'(busy), 64'd1);
        idle(10);
        chk("div0_hi", 64'(hi), 64'h11);
        chk("div0_lo", 64'(lo), 64'h22);

        // MTHI, and MTLO dropped during a MULT run
        step(1'b1, 4'd5, 32'hDEADBEEF, 32'd0);
        chk("mthi_hi", 64'(hi), 64'hDEADBEEF);
        chk("mthi_busy", 64'(busy), 64'd0);
        step(1'b1, 4'd1, 32'd3, 32'd4);
        step(1'b1, 4'd6, 32'h55, 32'd0);
        idle(4);
        chk("ign_lo", 64'(lo), 64'd12);
        chk("ign_hi", 64'(hi), 64'd0);

        // Asynchronous reset in the third busy cycle of a DIV
        step(1'b1, 4'd5, 32'hA5, 32'd0);
        step(1'b1, 4'd3, 32'd100, 32'd3);
        idle(2);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_hi", 64'(hi), 64'd0);
        chk("arst_lo", 64'(lo), 64'd0);
        m_rem = 0; m_pend = 64'd0; m_hi = 32'd0; m_lo = 32'd0;
        #1 reset = 1'b0;
        idle(12);
        chk("post_rst_hi", 64'(hi), 64'd0);

        // MADDU accumulate (or NONE when the feature is absent)
        step(1'b1, 4'd5, 32'd0, 32'd0);
        step(1'b1, 4'd6, 32'hFFFFFFFF, 32'd0);
        step(1'b1, 4'd8, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        chk("maddu_busy", 64'(busy), 64'd1);
        idle(5);
        chk("maddu_hi", 64'(hi), 64'd1);
        chk("maddu_lo", 64'(lo), 64'd0);
`else
        chk("maddu_busy", 64'(busy), 64'd0);
        idle(5);
        chk("maddu_hi", 64'(hi), 64'd0);
        chk("maddu_lo", 64'(lo), 64'hFFFFFFFF);
`endif

        // Random traffic, including starts while busy and divide by zero
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), rnd_operand(), rnd_operand());
        end
        idle(12);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit %0d", 200000);
        $fatal(1, "timeout");
    end
endmodule
